// File: rtl/hfifo_push_arbiter_pkg.sv
// Shared definitions for the hfifo push-side arbiter: FSM encoding and the
// elaboration-time log2 helper used to cross-check width parameters.
package hfifo_push_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hfifo_rr_pick.sv
// Rotating-priority encoder: first requester with req=1 scanning from
// rr_last+1 upward, modulo NREQ.
module hfifo_rr_pick #(
    parameter int NREQ   = 4,
    parameter int IWIDTH = 2
) (
    input  logic [NREQ-1:0]   req,
    input  logic [IWIDTH-1:0] rr_last,
    output logic [IWIDTH-1:0] pick,
    output logic              any
);

    logic [IWIDTH-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        pick = rr_last;
        any  = 1'b0;
        idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IWIDTH'((int'(rr_last) + k) % NREQ);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hfifo_push_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO push port among NREQ
// producers; bursts end on last, BURST_MAX words, or the owner dropping req.
module hfifo_push_arbiter
    import hfifo_push_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int IWIDTH    = 2,
    parameter int DWIDTH    = 8,
    parameter int BURST_MAX = 4,
    parameter int BWIDTH    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [NREQ*DWIDTH-1:0] din,
    output logic [NREQ-1:0]        gnt,
    output logic [DWIDTH-1:0]      fifo_din,
    output logic                   fifo_push,
    input  logic                   fifo_not_full,
    output logic [IWIDTH-1:0]      owner,
    output logic                   busy
);

    if (IWIDTH != clog2(NREQ)) begin : g_bad_iwidth
        $error("hfifo_push_arbiter: IWIDTH must equal clog2(NREQ)");
    end
    if (BWIDTH != clog2(BURST_MAX) + 1) begin : g_bad_bwidth
        $error("hfifo_push_arbiter: BWIDTH must equal clog2(BURST_MAX)+1");
    end

    state_t            state;
    logic [IWIDTH-1:0] rr_last;
    logic [IWIDTH-1:0] pick;
    logic [BWIDTH-1:0] beat;
    logic              room;
    logic              any;
    logic              owner_req;
    logic              burst_end;

    hfifo_rr_pick #(
        .NREQ   (NREQ),
        .IWIDTH (IWIDTH)
    ) u_pick (
        .req     (req),
        .rr_last (rr_last),
        .pick    (pick),
        .any     (any)
    );

    assign busy      = (state == ST_BURST);
    assign owner_req = req[owner];
    // room is last cycle's not_full, so push never depends on not_full combinationally.
    assign fifo_push = busy & owner_req & room;
    assign fifo_din  = busy ? din[owner*DWIDTH +: DWIDTH] : '0;
    assign burst_end = fifo_push & (last[owner] | (beat == BWIDTH'(BURST_MAX - 1)));

    always_comb begin
        gnt        = '0;
        gnt[owner] = fifo_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= '0;
            rr_last <= IWIDTH'(NREQ - 1);
            beat    <= '0;
            room    <= 1'b0;
        end else begin
            room <= fifo_not_full;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        owner <= pick;
                        beat  <= '0;
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (fifo_push) begin
                        beat <= beat + BWIDTH'(1);
                    end
                    if (burst_end || !owner_req) begin
                        state   <= ST_IDLE;
                        rr_last <= owner;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
